// File: rtl/serial_frame_receiver_if.sv
// Bundle of the serial-in / parallel-out signals of serial_frame_receiver.
// The slave modport is the receiver; the master modport is the bit source and word consumer.
interface serial_frame_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 BitIn;
  logic                 BitValid;
  logic [DATA_BITS-1:0] Data;
  logic                 DataValid;
  logic                 FrameError;
  logic                 Busy;
  logic [1:0]           dbg_state;

  modport slave (
    input  BitIn,
    input  BitValid,
    output Data,
    output DataValid,
    output FrameError,
    output Busy,
    output dbg_state
  );

  modport master (
    output BitIn,
    output BitValid,
    input  Data,
    input  DataValid,
    input  FrameError,
    input  Busy,
    input  dbg_state
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// Assembles start / DATA_BITS (LSB first) / [even parity] / stop frames from a strobed bit stream.
// Optional parity bit enabled by defining PARITY_EN.
//
// Handshake: BitIn is consumed only on rising edges where BitValid=1; there is no
// back-pressure. DataValid and FrameError are single-cycle registered pulses after
// the stop-bit edge, never both high; Data holds the last good word.
module serial_frame_receiver #(
  parameter int DATA_BITS = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  serial_frame_receiver_if.slave bus
);

  localparam int CW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd3
  } state_e;
`endif

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 fe_q, fe_d;
  logic                 par_ok;

`ifdef PARITY_EN
  logic par_q, par_d;
  // Even parity: data bits XOR parity bit must be zero.
  assign par_ok = ~(^shift_q ^ par_q);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    if (bus.BitValid) begin
      case (state_q)
        IDLE: begin
          if (!bus.BitIn) begin
            state_d = DATA;
            cnt_d   = '0;
            shift_d = '0;
`ifdef PARITY_EN
            par_d   = 1'b0;
`endif
          end
        end
        DATA: begin
          // Place the bit at its index so the word lands LSB first.
          for (int i = 0; i < DATA_BITS; i++) begin
            if (cnt_q == CW'(i)) shift_d[i] = bus.BitIn;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          par_d   = bus.BitIn;
          state_d = STOP;
        end
`endif
        STOP: begin
          state_d = IDLE;
          if (bus.BitIn && par_ok) begin
            data_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            fe_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.Data       = data_q;
  assign bus.DataValid  = dv_q;
  assign bus.FrameError = fe_q;
  assign bus.Busy       = (state_q != IDLE);
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver: frame driver, expected-result queue, report.
module tb_serial_frame_receiver;

  localparam int DB = 8;
  localparam int W  = DB + 2;
`ifdef PARITY_EN
  localparam int LAT = DB + 3;
`else
  localparam int LAT = DB + 2;
`endif

  logic Clock;
  logic Reset;

  serial_frame_receiver_if #(.DATA_BITS(DB)) bus ();

  serial_frame_receiver #(.DATA_BITS(DB)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int unsigned cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry: {DataValid, FrameError, Data} expected at the pulse.
  logic [W-1:0] exp_q[$];
  logic [DB-1:0] last_good = '0;
  int unsigned pulse_cyc = 0;
  int unsigned prev_pulse_cyc = 0;
  int unsigned start_cyc = 0;

  always @(negedge Clock) begin
    if (!Reset && (bus.DataValid || bus.FrameError)) begin
      prev_pulse_cyc <= pulse_cyc;
      pulse_cyc      <= cyc;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {22'd0, bus.DataValid, bus.FrameError, bus.Data}, 32'd0);
      end else begin
        check_eq("frame", {22'd0, bus.DataValid, bus.FrameError, bus.Data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, input int gap);
    bus.BitIn    = b;
    bus.BitValid = 1'b1;
    @(posedge Clock);
    #1;
    bus.BitValid = 1'b0;
    bus.BitIn    = 1'($urandom_range(0, 1));
    repeat (gap) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par_flip,
                            input int gap);
    logic fe;
`ifdef PARITY_EN
    fe = !stop || par_flip;
`else
    fe = !stop;
`endif
    if (!fe) last_good = d;
    exp_q.push_back({!fe, fe, last_good});
    send_bit(1'b0, gap);
    start_cyc = cyc;
    for (int i = 0; i < DB; i++) send_bit(d[i], gap);
`ifdef PARITY_EN
    send_bit((^d) ^ par_flip, gap);
`endif
    send_bit(stop, 0);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge Clock);
      #1;
      k++;
    end
    @(posedge Clock);
    #1;
    check_eq("drain_timeout", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.BitIn    = 1'b1;
    bus.BitValid = 1'b0;
    Reset        = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;

    check_eq("rst_data", bus.Data, 0);
    check_eq("rst_dv", bus.DataValid, 0);
    check_eq("rst_fe", bus.FrameError, 0);
    check_eq("rst_busy", bus.Busy, 0);
    check_eq("rst_state", bus.dbg_state, 0);

    // Idle strobes of 1 are not start bits.
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    check_eq("idle_ones_busy", bus.Busy, 0);

    // Good frame A5 with strobe held high.
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    wait_drain();
    check_eq("latency", pulse_cyc - start_cyc + 1, LAT);
    check_eq("a5_data", bus.Data, 8'hA5);
    check_eq("a5_busy_after", bus.Busy, 0);

    // Bad stop bit: error pulse, Data holds.
    send_frame(8'hA5, 1'b0, 1'b0, 0);
    wait_drain();
    check_eq("stoperr_data_hold", bus.Data, 8'hA5);

    // 3C with 3 idle cycles between bits; state must hold across gaps.
    bus.BitIn = 1'b0;
    send_bit(1'b0, 3);
    check_eq("gap_busy_after_start", bus.Busy, 1);
    exp_q.push_back({1'b1, 1'b0, 8'h3C});
    last_good = 8'h3C;
    for (int i = 0; i < DB; i++) begin
      send_bit(((8'h3C >> i) & 8'h01) != 0, 3);
      check_eq("gap_busy", bus.Busy, 1);
    end
`ifdef PARITY_EN
    send_bit(^(8'h3C), 3);
`endif
    send_bit(1'b1, 0);
    wait_drain();
    check_eq("gap_data", bus.Data, 8'h3C);

    // Back-to-back 01 then FF.
    send_frame(8'h01, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 0);
    wait_drain();
    check_eq("b2b_spacing", pulse_cyc - prev_pulse_cyc, LAT);
    check_eq("b2b_data", bus.Data, 8'hFF);

    // Abort after 4 data bits; reset wins over a concurrent strobe.
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    bus.BitValid = 1'b1;
    bus.BitIn    = 1'b0;
    Reset        = 1'b1;
    @(posedge Clock);
    #1;
    Reset        = 1'b0;
    bus.BitValid = 1'b0;
    bus.BitIn    = 1'b1;
    last_good    = '0;
    check_eq("abort_busy", bus.Busy, 0);
    check_eq("abort_state", bus.dbg_state, 0);
    check_eq("abort_data", bus.Data, 0);
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    wait_drain();
    check_eq("after_abort_data", bus.Data, 8'h5A);

`ifdef PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 0);
    wait_drain();
    check_eq("par_good_data", bus.Data, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 0);
    wait_drain();
    check_eq("par_bad_data_hold", bus.Data, 8'h07);
`endif

    // Random frames: random words, stop bits, gaps.
    for (int n = 0; n < 12; n++) begin
      send_frame(DB'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) send_bit(1'b1, $urandom_range(0, 2));
    end
    wait_drain();
    check_eq("rand_final_data", bus.Data, last_good);
    check_eq("rand_final_busy", bus.Busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Both pulses high together is never legal.
  always @(negedge Clock) begin
    if (bus.DataValid && bus.FrameError) check_eq("dv_fe_both", 1, 0);
  end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Downstream consumer of the single-bit D flip-flop stage: takes the flip-flop's registered output Q as a serial bit stream, qualified by that stage's Enable strobe, and assembles framed serial words (start bit, DATA_BITS data bits LSB first, optional even parity, stop bit) into a parallel word. It presents each word with a one-cycle valid pulse and flags malformed frames, sitting between the bit-storage stage and any parallel consumer such as a register or display driver.

## Interface
- DATA_BITS, default 8, number of data bits per frame; legal range 1..16.
- Clock  input  1  rising-edge clock shared with the upstream flip-flop.
- Reset  input  1  synchronous, active-high reset; sampled on the rising edge of Clock.
- BitIn  input  1  serial bit; connected to upstream flip-flop Q.
- BitValid  input  1  sample strobe; BitIn is consumed only on edges where BitValid=1. Connected to upstream Enable.
- Data  output  DATA_BITS  last successfully received word.
- DataValid  output  1  one-cycle pulse: Data just updated with a good frame.
- FrameError  output  1  one-cycle pulse: frame rejected on stop or parity failure.
- Busy  output  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- FSM states: IDLE, DATA, PARITY (only with PARITY_EN), STOP.
- IDLE: on a strobe with BitIn=0 (start bit) → DATA; clear bit counter and shift register. A strobe with BitIn=1 is ignored.
- DATA: each strobe shifts BitIn into the shift register at bit index = counter (LSB first) and increments the counter. The strobe that takes bit DATA_BITS-1 → PARITY if enabled, else → STOP.
- PARITY: a strobe captures the parity bit → STOP.
- STOP: a strobe with BitIn=1 and parity OK → Data ← shift register, DataValid=1, → IDLE. BitIn=0 or parity mismatch → FrameError=1, Data unchanged, → IDLE.
- No BitValid on an edge: state, counter and shift register hold; DataValid/FrameError are 0.
- Bit counter width: $clog2(DATA_BITS)+1; it never wraps within a frame.
- A new start bit is accepted on the first strobe after return to IDLE; back-to-back frames are allowed with no idle bits.
- Data persists until the next good frame; FrameError does not alter Data.

## Timing
- Reset values: Data=0, DataValid=0, FrameError=0, Busy=0, state IDLE, counter 0.
- Reset mid-frame: the partial frame is discarded, no pulse is issued, and the block is in IDLE on the next cycle. Reset overrides a simultaneous BitValid.
- All outputs are registered and change only on the rising edge of Clock.
- Busy rises on the edge that samples the start bit and falls on the edge that samples the stop bit.
- DataValid and FrameError are high for exactly the one cycle following the stop-bit edge. Both are never high together.
- Latency with BitValid held high: DATA_BITS+2 edges from start-bit edge to DataValid (DATA_BITS+3 with PARITY_EN).

## Configuration
- PARITY_EN defined: a parity bit follows the data bits. Even parity applies: the XOR of data bits and the parity bit must be 0, otherwise FrameError is raised at STOP. The PARITY state exists.
- PARITY_EN undefined: no parity bit, no PARITY state, and FrameError arises from the stop bit only.

## Test plan
- Reset, then BitValid=1 with frame 0, bits 1,0,1,0,0,1,0,1 (LSB first), 1 → Data=8'hA5, DataValid pulse for 1 cycle, 10 edges after the start bit, Busy low afterward.
- Same frame with stop bit 0 → FrameError pulse, DataValid stays 0, Data holds its previous value (8'hA5 after a prior good frame).
- Frame for 8'h3C with BitValid deasserted for 3 cycles between every bit → Data=8'h3C. State holds across gaps, and no pulse appears early.
- Two back-to-back frames 8'h01 then 8'hFF with no idle bits → two DataValid pulses 10 edges apart, Data=8'hFF at the end.
- Reset asserted after 4 data bits, then a clean frame 8'h5A → no pulse for the aborted frame, Data=8'h5A afterward.
- PARITY_EN: frame 8'h07 with parity 1 → DataValid. Same frame with parity 0 → FrameError, Data unchanged.
